// File: rtl/gray_counter_display_sys.sv
// gray_counter_display_sys
//
// Board-level top for the Gray counter demo. A bouncing push button is
// synchronised and debounced; every press (0->1 of the debounced level) steps
// an N-bit binary counter up or down according to the synchronised dir input.
// The Gray code of the count drives the LEDs. The same Gray value is shown in
// hex on a DIGITS-digit multiplexed 7-segment display. A snapshot is taken
// once per full scan, so a single scan never mixes old and new digits.
//
// Ports:
//   clk    in   1       system clock, rising edge
//   reset  in   1       asynchronous, active-low reset
//   noisy  in   1       raw push button, active-high, asynchronous
//   dir    in   1       count direction (1 = up, 0 = down), asynchronous
//   leds   out  N       registered Gray code of the count
//   an     out  DIGITS  digit anodes, active-low, one-hot-low while scanning
//   seg    out  7       segments a..g (seg[6] = a), active-low
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (any digit i > 0 whose nibble and all
//   higher nibbles of the snapshot are zero) keep their anode high during
//   their scan slot. Digit 0 is always lit. Scan timing is unchanged.
module gray_counter_display_sys #(
  parameter int N               = 8,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              noisy,
  input  logic              dir,
  output logic [N-1:0]      leds,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int PS_W   = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SNAP_W = 4 * DIGITS;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Binary to Gray conversion.
  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Hex nibble to active-low segments, seg[6] = a .. seg[0] = g.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Stage p0/p1: two-flop synchronisers; nothing else sees noisy or dir.
  // ---------------------------------------------------------------------
  logic noisy_p0, noisy_p1;
  logic dir_p0, dir_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      noisy_p0 <= 1'b0;
      noisy_p1 <= 1'b0;
      dir_p0   <= 1'b0;
      dir_p1   <= 1'b0;
    end else begin
      noisy_p0 <= noisy;
      noisy_p1 <= noisy_p0;
      dir_p0   <= dir;
      dir_p1   <= dir_p0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage p2: debounce and press edge detect.
  // ---------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            debounced;
  logic            debounced_p2;
  logic            step;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt       <= '0;
      debounced    <= 1'b0;
      debounced_p2 <= 1'b0;
    end else begin
      debounced_p2 <= debounced;
      if (noisy_p1 != debounced) begin
        if (db_cnt == DB_LAST) begin
          debounced <= ~debounced;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Only the rising edge of the debounced level steps the counter.
  assign step = debounced & ~debounced_p2;

  // ---------------------------------------------------------------------
  // Stage p3: up/down counter with Gray output registered alongside it.
  // ---------------------------------------------------------------------
  logic [N-1:0] bin;
  logic [N-1:0] bin_next;

  always_comb begin
    bin_next = bin;
    if (step) begin
      bin_next = dir_p1 ? (bin + 1'b1) : (bin - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin  <= '0;
      leds <= '0;
    end else if (step) begin
      bin  <= bin_next;
      leds <= to_gray(bin_next);
    end
  end

  // ---------------------------------------------------------------------
  // Scan: prescaler, digit index and per-scan snapshot.
  // ---------------------------------------------------------------------
  logic [PS_W-1:0]   pre;
  logic [IDX_W-1:0]  idx;
  logic [SNAP_W-1:0] snap;
  logic [SNAP_W-1:0] snap_src;
  logic              scan_tick;
  logic              scan_wrap;

  // Gray value zero-extended (or truncated) to the display width.
  generate
    if (N >= SNAP_W) begin : g_snap_trunc
      assign snap_src = leds[SNAP_W-1:0];
    end else begin : g_snap_ext
      assign snap_src = {{(SNAP_W - N){1'b0}}, leds};
    end
  endgenerate

  assign scan_tick = (pre == PS_LAST);
  assign scan_wrap = scan_tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      idx  <= '0;
      snap <= '0;
    end else begin
      pre <= scan_tick ? '0 : (pre + 1'b1);
      if (scan_tick) begin
        idx <= (idx == IDX_LAST) ? '0 : (idx + 1'b1);
      end
      // Loading only as the index returns to 0 keeps a whole scan coherent.
      if (scan_wrap) begin
        snap <= snap_src;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Display output registers: anode and segments change together.
  // ---------------------------------------------------------------------
  logic [3:0]        nibble;
  logic [DIGITS-1:0] an_next;
  logic              blank;

  assign nibble  = snap[{idx, 2'b00} +: 4];
  assign an_next = ~(DIGITS'(1) << idx);

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i] is set when nibble i and every higher nibble are zero.
  logic [DIGITS-1:0] lead_zero;
  logic              hi_zero;

  always_comb begin
    lead_zero = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero      = hi_zero & (snap[4*i +: 4] == 4'h0);
      lead_zero[i] = hi_zero;
    end
  end

  assign blank = lead_zero[idx] && (idx != '0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= 7'b1111111;
    end else begin
      an  <= blank ? '1 : an_next;
      seg <= hex7(nibble);
    end
  end

endmodule

// File: doc/gray_counter_display_sys.md
Name: gray_counter_display_sys

Overview:
Parametrised successor to the fixed 8-bit Gray counter display top level. It adds the following to that design:
- N-bit up/down Gray counter stepped by a debounced push button.
- Synchronised direction input.
- Generic D-digit multiplexed hex 7-segment driver with tear-free snapshotting.

It is the board-level top for the counter demo and drives the LEDs and the 7-segment digits directly.

Parameters:
N, 8, counter width in bits (2..16)
DIGITS, 4, number of 7-segment digits (1..8); digit i shows nibble i of the Gray value, zero-extended to 4*DIGITS bits
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button changes (>=2)
SCAN_DIV, 50000, clock cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
noisy  input  1  raw bouncing push button, active-high, asynchronous
dir  input  1  count direction, 1=up 0=down, asynchronous
leds  output  N  registered Gray code of the count
an  output  DIGITS  digit anodes, active-low, one-hot-low while scanning
seg  output  7  segments a..g, seg[6]=a .. seg[0]=g, active-low

Behaviour:
- Reset (reset=0) applies asynchronously, with immediate effect at any time:
  - bin=0, leds=0, debounced=0, sync FFs=0.
  - Debounce counter, prescaler and digit index =0; snapshot=0.
  - an=all ones, seg=7'b1111111.
- Synchronisers: noisy and dir each pass through 2 FFs. No other logic may see the raw inputs.
- Debounce:
  - The counter increments while the synced noisy differs from debounced, and clears to 0 whenever they are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing: debounced toggles and the counter clears.
- Step: exactly one step per 0->1 transition of debounced. A 1->0 transition produces no step.
- Counter, on a step:
  - Synced dir=1: bin <= bin+1 mod 2^N.
  - Synced dir=0: bin <= bin-1 mod 2^N.
  - Wrap: 2^N-1 up -> 0; 0 down -> 2^N-1.
  - leds = bin ^ (bin>>1), registered in the same cycle as bin.
- Latency: leds changes exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling a stable noisy=1.
- dir changes never cause a step on their own.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At terminal count, the digit index advances and wraps DIGITS-1 -> 0.
  - When the index wraps to 0, the snapshot loads leds. The display therefore never shows a mixed old/new value within one scan.
  - After reset release, the first edge gives an[0]=0, others 1, index 0.
  - an and seg are registered and change in the same cycle.
- Hex decode: 0-F -> standard glyphs 0123456789AbCdEF, active-low. Examples: 0=0000001, 1=1001111, 8=0000000, F=0111000.
- The scan runs continuously and is independent of counting.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: any digit i>0 whose nibble and all higher nibbles of the snapshot are 0 keeps its anode high (blank) during its scan slot. Digit 0 is always lit.
- Undefined: all digits are lit in their slot, and leading zeros are displayed.
- Scan timing is identical in both cases.

Test Plan:
(Sim parameters: N=8, DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_DIV=4; macro undefined unless stated.)
1. Reset low for 3 cycles, then release -> during reset an=1111, seg=1111111, leds=00. On the first edge after release, an=1110 and seg=0000001.
2. dir=1, three clean presses (high 10 cycles, low 10 cycles) -> leds 01, 03, 02 in sequence. Each change occurs 7 edges after noisy is first sampled high.
3. noisy toggling every 2 cycles for 20 cycles, then held high -> exactly one step (leds 00->01). No step occurs on release.
4. From reset, dir=0, one press -> bin=FF, leds=80. After the next scan wrap: digit1 seg=0000000 ('8'); digits 0, 2 and 3 show 0000001.
5. Scan sequence -> an goes 1110, 1101, 1011, 0111, 1110, each held 4 cycles. A step landing mid-scan is not displayed until an returns to 1110.
6. Reset asserted mid-debounce (counter=2), then released with noisy high -> leds stays 00 until a full debounce completes. Also rerun scenario 4 with LEADING_ZERO_BLANK_EN defined -> digits 2 and 3 anodes stay high; digits 0 and 1 are lit.
